// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: valid/ready FIFO controller for a 1-cycle-latency RAM.
// A 2-entry head/skid buffer hides the RAM read latency, so words fall through at 1 word/cycle.
module spram_fifo_ctrl #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(SIZE+3)-1:0] level,
    output logic                     ram_wen,
    output logic                     ram_ren,
    output logic [$clog2(SIZE)-1:0]  ram_waddr,
    output logic [$clog2(SIZE)-1:0]  ram_raddr,
    output logic [WIDTH-1:0]         ram_wdata,
    input  logic [WIDTH-1:0]         ram_rdata
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);
    localparam int LW = $clog2(SIZE + 3);

    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_ram_cnt;
    logic             r_inflight;
    logic [1:0]       r_out_cnt;
    logic [WIDTH-1:0] r_head, r_skid;
    logic             w_push, w_pop;
    logic [1:0]       w_left;
    logic [2:0]       w_occ;

    assign in_ready  = r_ram_cnt != CW'(SIZE);
    assign w_push    = in_valid & in_ready;
    assign out_valid = r_out_cnt != 2'd0;
    assign w_pop     = out_valid & out_ready;
    // Buffer slots still occupied after this cycle's pop, plus the read already in flight
    assign w_left    = r_out_cnt - {1'b0, w_pop};
    assign w_occ     = {1'b0, w_left} + {2'b0, r_inflight};
    assign ram_ren   = (r_ram_cnt != '0) & (w_occ < 3'd2);
    assign ram_wen   = w_push;
    assign ram_waddr = r_wptr;
    assign ram_raddr = r_rptr;
    assign ram_wdata = in_data;
    assign out_data  = r_head;
    assign level     = LW'(r_ram_cnt) + LW'(r_inflight) + LW'(r_out_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_out_cnt  <= 2'd0;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == AW'(SIZE - 1)) ? '0 : r_wptr + 1'b1;
            if (ram_ren)
                r_rptr <= (r_rptr == AW'(SIZE - 1)) ? '0 : r_rptr + 1'b1;
            r_ram_cnt  <= r_ram_cnt + CW'(w_push) - CW'(ram_ren);
            r_inflight <= ram_ren;
            r_out_cnt  <= w_left + {1'b0, r_inflight};
            // Returning read data lands in the first slot free after the pop
            if (r_inflight && w_left == 2'd0)
                r_head <= ram_rdata;
            else if (w_pop && r_out_cnt == 2'd2)
                r_head <= r_skid;
            if (r_inflight && w_left == 2'd1)
                r_skid <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb_spram_fifo_ctrl: scoreboard bench with a RAM model; expected words come from a queue of accepted inputs.
module tb_spram_fifo_ctrl;
    localparam int WIDTH = 16;
    localparam int SIZE  = 32;
    localparam int AW    = $clog2(SIZE);
    localparam int LW    = $clog2(SIZE + 3);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic             ram_wen, ram_ren;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata = '0;

    logic [WIDTH-1:0] mem [SIZE];
    logic [WIDTH-1:0] q_d [$];
    int               q_t [$];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    spram_fifo_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .ram_wen(ram_wen), .ram_ren(ram_ren),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= ram_ren ? mem[ram_raddr] : '0;
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: the FIFO content is exactly the accepted-but-not-popped words
    always @(negedge clk) begin
        if (rst) begin
            q_d.delete();
            q_t.delete();
        end else begin
            chk(level == LW'(q_d.size()), "level", 32'(level), q_d.size());
            chk(level <= LW'(SIZE + 2), "level_max", 32'(level), SIZE + 2);
            chk(ram_wen == (in_valid && in_ready), "ram_wen", 32'(ram_wen), 32'(in_valid && in_ready));
            if (q_d.size() < SIZE)
                chk(in_ready, "in_ready", 32'(in_ready), 1);
            if (ram_wen && ram_ren)
                chk(ram_waddr != ram_raddr, "addr_collision", 32'(ram_waddr), 32'(ram_raddr));
            if (out_valid) begin
                if (q_d.size() == 0)
                    chk(1'b0, "spurious_out_valid", 1, 0);
                else
                    chk(out_data == q_d[0], "out_data", 32'(out_data), 32'(q_d[0]));
            end else if (q_d.size() > 0) begin
                chk(cyc - q_t[0] <= 2, "head_latency", cyc - q_t[0], 2);
            end
            if (out_valid && out_ready && q_d.size() > 0) begin
                void'(q_d.pop_front());
                void'(q_t.pop_front());
            end
            if (in_valid && in_ready) begin
                q_d.push_back(in_data);
                q_t.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            if (q_d.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(done, "drain_timeout", q_d.size(), 0);
    endtask

    initial begin
        int acc;
        do_reset();
        @(negedge clk);
        chk(!out_valid && level == 0 && in_ready, "reset_state", {level, out_valid, in_ready}, 1);
        chk(out_data == 0, "reset_out_data", 32'(out_data), 0);
        chk(!ram_wen && !ram_ren && ram_waddr == 0 && ram_raddr == 0, "reset_ram",
            {ram_waddr, ram_raddr, ram_wen, ram_ren}, 0);

        // Single word latency
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
        @(negedge clk);
        chk(ram_wen && ram_waddr == 0, "single_wen", {ram_waddr, ram_wen}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(ram_ren && ram_raddr == 0, "single_ren", {ram_raddr, ram_ren}, 1);
        @(negedge clk);
        chk(!out_valid, "single_not_yet", 32'(out_valid), 0);
        @(negedge clk);
        chk(out_valid && out_data == 16'h00A5, "single_out", {out_data, out_valid}, {16'h00A5, 1'b1});
        @(negedge clk);
        chk(level == 0, "single_level", 32'(level), 0);

        // Streaming with pointer wrap
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = WIDTH'(i); out_ready = 1'b1;
        end
        @(negedge clk);
        chk(level == 3, "stream_level", 32'(level), 3);
        drain();

        // Full
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b0; in_data = WIDTH'(acc);
            @(negedge clk);
            if (in_ready) acc++;
        end
        chk(acc == SIZE + 2, "full_accepts", acc, SIZE + 2);
        chk(level == SIZE + 2, "full_level", 32'(level), SIZE + 2);
        chk(!in_ready, "full_in_ready", 32'(in_ready), 0);
        chk(out_data == 0, "full_head", 32'(out_data), 0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(in_ready, "full_reopen", 32'(in_ready), 1);
        drain();

        // Random backpressure
        acc = 0;
        for (int i = 0; i < 2000 && acc < 200; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = WIDTH'($urandom); out_ready = $urandom_range(0, 99) < 30;
            @(negedge clk);
            if (in_ready) acc++;
        end
        chk(acc == 200, "bp_accepts", acc, 200);
        drain();

        // Reset mid-stream with a read in flight
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = WIDTH'(16'hB000 + i); out_ready = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk(level == 10, "pre_reset_level", 32'(level), 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(!out_valid && level == 0 && in_ready, "midreset_state", {level, out_valid, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk(out_valid && out_data == 16'h1234, "midreset_first", {out_data, out_valid}, {16'h1234, 1'b1});
        drain();

        // Alternating bursts with out_ready toggling every cycle
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 3 != 2) && $urandom_range(0, 1) == 1;
            in_data = WIDTH'($urandom);
            out_ready = (i % 2) == 1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
